// File: rtl/ahb_lite_pkg.sv
// Shared types and helpers for the AHB-lite SRAM slave.
//   htrans_e   : AHB transfer type encoding
//   hresp_e    : AHB response encoding
//   dp_state_e : data-phase state of the slave
//   HSIZE_*    : hsize encodings up to a doubleword
//   byte_strobe: lane mask for a transfer of 2**hsize bytes at a lane offset
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    DP_IDLE = 2'd0,
    DP_WAIT = 2'd1,
    DP_ERR1 = 2'd2,
    DP_ERR2 = 2'd3
  } dp_state_e;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  // Widest supported bus is 64 bits; narrower buses use the low lanes.
  localparam int unsigned MAX_LANES = 8;

  function automatic logic [MAX_LANES-1:0] byte_strobe(input logic [2:0] addr_lsbs,
                                                       input logic [2:0] hsize);
    logic [MAX_LANES-1:0] strb;
    int unsigned          nbytes;
    strb = '0;
    case (hsize)
      HSIZE_BYTE:  nbytes = 1;
      HSIZE_HALF:  nbytes = 2;
      HSIZE_WORD:  nbytes = 4;
      HSIZE_DWORD: nbytes = 8;
      default:     nbytes = 0;
    endcase
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      strb[i] = (i >= 32'(addr_lsbs)) && (i < 32'(addr_lsbs) + nbytes);
    end
    return strb;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_array.sv
// Word-organised SRAM with per-byte write enables and a combinational read.
// Contents are not reset.
//   hclk_i  : clock, rising edge
//   we_i    : write enable
//   be_i    : byte-lane enables (lane 0 = bits 7:0)
//   addr_i  : word address, shared by read and write
//   wdata_i : write data
//   rdata_o : read data of the word at addr_i
module ahb_lite_sram_array #(
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                          hclk_i,
  input  logic                          we_i,
  input  logic [DATA_WIDTH/8-1:0]       be_i,
  input  logic [$clog2(MEM_DEPTH)-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]         wdata_i,
  output logic [DATA_WIDTH-1:0]         rdata_o
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge hclk_i) begin
    if (we_i) begin
      for (int unsigned b = 0; b < NUM_LANES; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite slave in front of a byte-lane SRAM, with programmable wait states
// and the two-cycle ERROR response for out-of-range, misaligned or oversize
// transfers.
//   hclk, hresetn       : clock, async active-low reset
//   hsel, haddr, htrans : select, byte address, transfer type
//   hwrite, hsize       : direction, log2 of transfer bytes
//   hburst, hprot       : accepted but unused
//   hready              : bus ready; address phase sampled only when high
//   hwdata              : write data (data phase)
//   hrdata              : read data, zero outside OKAY read data phases
//   hreadyout, hresp    : slave ready and response
//
// state   | meaning
// DP_IDLE | no data phase, or the completing cycle of an OKAY data phase
// DP_WAIT | OKAY data phase stalled, wait counter running
// DP_ERR1 | first ERROR cycle, hreadyout low
// DP_ERR2 | second ERROR cycle, hreadyout high
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
  localparam int unsigned WORD_BITS = $clog2(MEM_DEPTH);
  localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(NUM_LANES);

  dp_state_e              state_q, state_d;
  logic [3:0]             wait_cnt_q, wait_cnt_d;
  logic                   active_q, active_d;   // an OKAY data phase is in flight
  logic                   write_q, write_d;
  logic [2:0]             size_q, size_d;
  logic [WORD_BITS-1:0]   word_q, word_d;
  logic [LANE_BITS-1:0]   lane_q, lane_d;

  logic                   accept;
  logic                   range_err, align_err, size_err, addr_err;
  logic [6:0]             align_mask;
  logic [MAX_LANES-1:0]   strb_all;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic                   unused_ok;

  assign accept = hsel & hready & htrans[1];

  assign range_err  = 64'(haddr) >= MEM_BYTES;
  assign align_mask = (7'd1 << hsize) - 7'd1;
  assign align_err  = |(haddr[6:0] & align_mask);
  assign size_err   = 32'(hsize) > LANE_BITS;
  assign addr_err   = range_err | align_err | size_err;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    active_d   = active_q;
    write_d    = write_q;
    size_d     = size_q;
    word_d     = word_q;
    lane_d     = lane_q;
    case (state_q)
      DP_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = DP_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      DP_ERR1: state_d = DP_ERR2;
      default: begin
        // DP_IDLE / DP_ERR2: hreadyout is high, so any current data phase
        // completes on this edge and a new address phase may be taken.
        state_d  = DP_IDLE;
        active_d = 1'b0;
        if (accept) begin
          write_d = hwrite;
          size_d  = hsize;
          word_d  = haddr[LANE_BITS +: WORD_BITS];
          lane_d  = haddr[LANE_BITS-1:0];
          if (addr_err) begin
            state_d = DP_ERR1;
          end else begin
            active_d = 1'b1;
            if (WAIT_STATES != 0) begin
              state_d    = DP_WAIT;
              wait_cnt_d = 4'(WAIT_STATES - 1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= DP_IDLE;
      wait_cnt_q <= 4'd0;
      active_q   <= 1'b0;
      write_q    <= 1'b0;
      size_q     <= 3'd0;
      word_q     <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      active_q   <= active_d;
      write_q    <= write_d;
      size_q     <= size_d;
      word_q     <= word_d;
      lane_q     <= lane_d;
    end
  end

  // Only the completing cycle of an OKAY write sits in DP_IDLE with active_q set.
  assign mem_we   = active_q & write_q & (state_q == DP_IDLE);
  assign strb_all = byte_strobe(3'(lane_q), size_q);

  ahb_lite_sram_array #(
    .MEM_DEPTH  (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .hclk_i  (hclk),
    .we_i    (mem_we),
    .be_i    (strb_all[NUM_LANES-1:0]),
    .addr_i  (word_q),
    .wdata_i (hwdata),
    .rdata_o (mem_rdata)
  );

  assign hreadyout = (state_q != DP_WAIT) && (state_q != DP_ERR1);
  assign hresp     = ((state_q == DP_ERR1) || (state_q == DP_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = (active_q && !write_q) ? mem_rdata : '0;

  assign unused_ok = ^{htrans[0], hburst, hprot, strb_all};

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
module tb_ahb_lite_sram_slave;

  localparam int NBYTES = 4096;

  logic        hclk = 1'b0;
  logic        hresetn   [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [3:0]  hprot     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  logic [7:0]  mem_m [2][NBYTES];
  int          n_checks = 0;
  int          n_errs   = 0;

  always #5 hclk = ~hclk;

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut_ws0 (
    .hclk(hclk), .hresetn(hresetn[0]), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hprot(hprot[0]),
    .hready(hreadyout[0]), .hwdata(hwdata[0]), .hrdata(hrdata[0]),
    .hreadyout(hreadyout[0]), .hresp(hresp[0]));

  ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(3)) u_dut_ws3 (
    .hclk(hclk), .hresetn(hresetn[1]), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hprot(hprot[1]),
    .hready(hreadyout[1]), .hwdata(hwdata[1]), .hrdata(hrdata[1]),
    .hreadyout(hreadyout[1]), .hresp(hresp[1]));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] s);
    int unsigned nb;
    nb = 32'd1 << s;
    return (a >= 32'(NBYTES)) || ((a % nb) != 0) || (nb > 4);
  endfunction

  function automatic logic [31:0] model_word(input int d, input logic [31:0] a);
    int unsigned base;
    base = a & ~32'd3;
    return {mem_m[d][base+3], mem_m[d][base+2], mem_m[d][base+1], mem_m[d][base]};
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wdata);
    int unsigned lane;
    for (int unsigned i = 0; i < (32'd1 << s); i++) begin
      lane = (a % 4) + i;
      mem_m[d][a + i] = wdata[8*lane +: 8];
    end
  endtask

  task automatic check_quiet(input int d, input string tag);
    check_val({tag, "_ready"}, 32'(hreadyout[d]), 32'd1);
    check_val({tag, "_resp"},  32'(hresp[d]),     32'd0);
    check_val({tag, "_rdata"}, hrdata[d],         32'd0);
  endtask

  // Single transfer followed by IDLE; data phase checked cycle by cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input logic [1:0] tr, output logic [31:0] rd);
    bit          err;
    logic [31:0] exp_rd;
    int          low;
    err = exp_err(addr, size);
    low = 0;
    hsel[d] = 1'b1; htrans[d] = tr; haddr[d] = addr; hwrite[d] = wr; hsize[d] = size;
    hwdata[d] = $urandom;
    tick();
    hsel[d] = 1'b0; htrans[d] = 2'b00; haddr[d] = $urandom; hwdata[d] = wdata;
    exp_rd = (!wr && !err) ? model_word(d, addr) : 32'd0;
    while (hreadyout[d] !== 1'b1 && low < 40) begin
      check_val("resp_wait", 32'(hresp[d]), 32'(err));
      check_val("rdata_wait", hrdata[d], exp_rd);
      low++;
      tick();
    end
    check_val("wait_cycles", 32'(low), 32'(err ? 1 : ws_of(d)));
    check_val("resp_done", 32'(hresp[d]), 32'(err));
    check_val("rdata_done", hrdata[d], exp_rd);
    rd = hrdata[d];
    tick();
    if (wr && !err) model_write(d, addr, size, wdata);
    check_quiet(d, "after_xfer");
  endtask

  // Pipelined write then read of the same address; address held during waits.
  task automatic wr_rd(input int d, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata, output logic [31:0] rd);
    logic [31:0] exp_rd;
    int          low;
    model_write(d, addr, size, wdata);
    exp_rd = model_word(d, addr);
    hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = addr; hwrite[d] = 1'b1; hsize[d] = size;
    tick();
    hwdata[d] = wdata; htrans[d] = 2'b11; hwrite[d] = 1'b0;
    low = 0;
    while (hreadyout[d] !== 1'b1 && low < 40) begin
      check_val("b2b_wr_rdata", hrdata[d], 32'd0);
      low++;
      tick();
    end
    check_val("b2b_wr_waits", 32'(low), 32'(ws_of(d)));
    check_val("b2b_wr_resp", 32'(hresp[d]), 32'd0);
    tick();
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = $urandom;
    low = 0;
    while (hreadyout[d] !== 1'b1 && low < 40) begin
      check_val("b2b_rd_wait_data", hrdata[d], exp_rd);
      low++;
      tick();
    end
    check_val("b2b_rd_waits", 32'(low), 32'(ws_of(d)));
    check_val("b2b_rd_data", hrdata[d], exp_rd);
    rd = hrdata[d];
    tick();
    check_quiet(d, "after_b2b");
  endtask

  task automatic idle_cycle(input int d, input logic [1:0] tr, input logic sel);
    hsel[d] = sel; htrans[d] = tr; haddr[d] = $urandom_range(0, 255); hwrite[d] = 1'($urandom);
    hsize[d] = 3'd2;
    tick();
    hsel[d] = 1'b0; htrans[d] = 2'b00;
    check_quiet(d, "idle_next");
    tick();
    check_quiet(d, "idle_next2");
  endtask

  initial begin
    logic [31:0] rd;
    logic [2:0]  sz;
    logic [31:0] a;
    int          kind;

    for (int d = 0; d < 2; d++) begin
      hresetn[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
      hsize[d] = 3'd0; hburst[d] = 3'd0; hprot[d] = 4'd0; hwdata[d] = '0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) check_quiet(d, "in_reset");
    hresetn[0] = 1'b1; hresetn[1] = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      check_quiet(d, "post_reset");
      idle_cycle(d, 2'b00, 1'b1);
      idle_cycle(d, 2'b01, 1'b1);
      idle_cycle(d, 2'b10, 1'b0);
    end

    // Known contents for the low 256 bytes, where all normal traffic goes.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++) xfer(d, 1'b1, 32'(w * 4), 3'd2, $urandom, 2'b10, rd);

    for (int d = 0; d < 2; d++) begin
      wr_rd(d, 32'h10, 3'd2, 32'hDEADBEEF, rd);
      check_val("b2b_deadbeef", rd, 32'hDEADBEEF);
      xfer(d, 1'b1, 32'h20, 3'd2, 32'h11223344, 2'b10, rd);
      xfer(d, 1'b1, 32'h22, 3'd0, 32'h00AA0000, 2'b10, rd);
      xfer(d, 1'b1, 32'h20, 3'd1, 32'h0000BBCC, 2'b10, rd);
      xfer(d, 1'b0, 32'h20, 3'd2, 32'h0, 2'b10, rd);
      check_val("lanes_merge", rd, 32'h11AABBCC);
      xfer(d, 1'b0, 32'h1000, 3'd2, 32'h0, 2'b10, rd);
      xfer(d, 1'b1, 32'h22, 3'd2, 32'h55667788, 2'b10, rd);
      xfer(d, 1'b1, 32'h20, 3'd3, 32'h99999999, 2'b10, rd);
      xfer(d, 1'b0, 32'h20, 3'd2, 32'h0, 2'b11, rd);
      check_val("after_errors", rd, 32'h11AABBCC);
    end

    // Reset during the second wait cycle of a write: no memory update.
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h40; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    tick();
    hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'hCAFEF00D;
    check_val("rst_wait1", 32'(hreadyout[1]), 32'd0);
    tick();
    check_val("rst_wait2", 32'(hreadyout[1]), 32'd0);
    hresetn[1] = 1'b0;
    #1;
    check_quiet(1, "rst_abort");
    tick(); tick();
    hresetn[1] = 1'b1;
    tick();
    xfer(1, 1'b0, 32'h40, 3'd2, 32'h0, 2'b10, rd);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        hburst[d] = 3'($urandom); hprot[d] = 4'($urandom);
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
          idle_cycle(d, 2'($urandom_range(0, 1)), 1'($urandom));
        end else if (kind == 1) begin
          sz = 3'($urandom_range(0, 2));
          a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
          wr_rd(d, a, sz, $urandom, rd);
        end else if (kind == 2) begin
          xfer(d, 1'($urandom), 32'(NBYTES) + 32'($urandom_range(0, 65535)),
               3'($urandom_range(0, 2)), $urandom, 2'b10, rd);
        end else begin
          sz = (kind == 3) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 2));
          a  = 32'($urandom_range(0, 255));
          if (kind > 5) a = a & ~((32'd1 << sz) - 32'd1);
          xfer(d, 1'($urandom), a, sz, $urandom, 2'($urandom_range(2, 3)), rd);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errs);
    $fatal(1, "watchdog");
  end

endmodule
